// File: rtl/adder_eval_pkg.sv
// Shared types and helpers for approximate-adder evaluation.
// Width defaults, monitor FSM states, saturating add.
package adder_eval_pkg;

  localparam int W_DEF     = 16;
  localparam int CNT_W_DEF = 32;
  localparam int ACC_W_DEF = 48;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // a + b clamped to (2**w)-1; operands must already fit in w bits
  function automatic logic [63:0] sat_add(
    input logic [63:0] a,
    input logic [63:0] b,
    input int unsigned w
  );
    logic [64:0] s;
    logic [64:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    if (s > lim) return lim[63:0];
    return s[63:0];
  endfunction

endpackage

// File: rtl/adder_err_dist.sv
// Exact sum, error distance and bit-error mask for one triple.
// Ports: a_i/b_i operands, sum_i approx sum; exact_o, ed_o, mask_o.
module adder_err_dist #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W:0]   sum_i,
  output logic [W:0]   exact_o,
  output logic [W:0]   ed_o,
  output logic [W:0]   mask_o
);

  assign exact_o = {1'b0, a_i} + {1'b0, b_i};

  // |exact - sum| by ordered subtract; never exceeds W+1 bits
  assign ed_o = (exact_o >= sum_i) ? (exact_o - sum_i)
                                   : (sum_i - exact_o);

  assign mask_o = exact_o ^ sum_i;

endmodule

// File: rtl/adder_err_monitor.sv
// Error-statistics monitor for an approximate adder under test.
// Ports: start/clear/num_samples control, in_* triple handshake, stat outputs.
module adder_err_monitor
  import adder_eval_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W:0]       in_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [W:0]       max_ed,
  output logic [ACC_W-1:0] sum_ed,
  output logic [W:0]       bit_err_mask
);

  state_e state_q, state_d;

  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] cnt_q;

  logic             s1_v_q;
  logic [W-1:0]     s1_a_q, s1_b_q;
  logic [W:0]       s1_s_q;

  logic             s2_v_q;
  logic [W:0]       s2_ed_q, s2_mask_q;

  logic             s3_v_q;
  logic [W:0]       s3_ed_q, s3_mask_q;

  logic [CNT_W-1:0] err_q;
  logic [W:0]       max_q;
  logic [ACC_W-1:0] sum_q;
  logic [W:0]       mask_q;

  logic [W:0]       dist_exact;
  logic [W:0]       dist_ed, dist_mask;

  logic flush;
  logic accept;
  logic last;

  // start/clear both wipe stats and in-flight triples
  assign flush  = clear | start;
  assign accept = in_valid & in_ready & ~flush;
  assign last   = accept & ((cnt_q + CNT_W'(1)) == num_q);

  assign num_d = (num_samples == '0) ? CNT_W'(1)
                                     : num_samples;

  adder_err_dist #(.W(W)) u_dist (
    .a_i    (s1_a_q),
    .b_i    (s1_b_q),
    .sum_i  (s1_s_q),
    .exact_o(dist_exact),
    .ed_o   (dist_ed),
    .mask_o (dist_mask)
  );

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN:     if (last) state_d = DRAIN;
        // S3 retires on the same edge we move to DONE
        DRAIN:   if (!s1_v_q && !s2_v_q) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      num_q   <= CNT_W'(1);
    end else begin
      state_q <= state_d;
      if (start && !clear) num_q <= num_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_s_q    <= '0;
      s2_v_q    <= 1'b0;
      s2_ed_q   <= '0;
      s2_mask_q <= '0;
      s3_v_q    <= 1'b0;
      s3_ed_q   <= '0;
      s3_mask_q <= '0;
    end else begin
      s1_v_q <= accept;
      s2_v_q <= s1_v_q & ~flush;
      s3_v_q <= s2_v_q & ~flush;
      if (accept) begin
        s1_a_q <= in_a;
        s1_b_q <= in_b;
        s1_s_q <= in_sum;
      end
      s2_ed_q   <= dist_ed;
      s2_mask_q <= dist_mask;
      s3_ed_q   <= s2_ed_q;
      s3_mask_q <= s2_mask_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      err_q  <= '0;
      max_q  <= '0;
      sum_q  <= '0;
      mask_q <= '0;
    end else if (flush) begin
      cnt_q  <= '0;
      err_q  <= '0;
      max_q  <= '0;
      sum_q  <= '0;
      mask_q <= '0;
    end else begin
      if (accept) cnt_q <= cnt_q + CNT_W'(1);
      if (s3_v_q) begin
        if (s3_mask_q != '0)
          err_q <= CNT_W'(sat_add(64'(err_q), 64'd1, CNT_W));
        if (s3_ed_q > max_q) max_q <= s3_ed_q;
        sum_q  <= ACC_W'(sat_add(64'(sum_q),
                                 64'(s3_ed_q), ACC_W));
        mask_q <= mask_q | s3_mask_q;
      end
    end
  end

  assign in_ready     = (state_q == RUN);
  assign busy         = (state_q == RUN) | (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign sample_cnt   = cnt_q;
  assign err_cnt      = err_q;
  assign max_ed       = max_q;
  assign sum_ed       = sum_q;
  assign bit_err_mask = mask_q;

endmodule

// File: tb/tb_adder_err_monitor.sv
// Scoreboard bench for adder_err_monitor.
// Default instance plus a narrow CNT_W=2/ACC_W=18 instance.
module tb_adder_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] num_samples = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [16:0] in_sum = '0;

  logic        in_ready, busy, done;
  logic [31:0] sample_cnt, err_cnt;
  logic [16:0] max_ed, mask;
  logic [47:0] sum_ed;

  logic        in_ready1, busy1, done1;
  logic [1:0]  sample_cnt1, err_cnt1;
  logic [16:0] max_ed1, mask1;
  logic [17:0] sum_ed1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] sc;
    logic [31:0] ec;
    logic [16:0] mx;
    logic [47:0] se;
    logic [16:0] mk;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  adder_err_monitor u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .clear(clear),
    .num_samples(num_samples), .in_valid(in_valid),
    .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_sum(in_sum), .busy(busy), .done(done),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .max_ed(max_ed), .sum_ed(sum_ed), .bit_err_mask(mask)
  );

  adder_err_monitor #(.W(16), .CNT_W(2), .ACC_W(18)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .clear(clear),
    .num_samples(num_samples[1:0]), .in_valid(in_valid),
    .in_ready(in_ready1), .in_a(in_a), .in_b(in_b),
    .in_sum(in_sum), .busy(busy1), .done(done1),
    .sample_cnt(sample_cnt1), .err_cnt(err_cnt1),
    .max_ed(max_ed1), .sum_ed(sum_ed1), .bit_err_mask(mask1)
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] sc, ec,
                      input logic [16:0] mx,
                      input logic [47:0] se,
                      input logic [16:0] mk);
    exp_t e;
    e.sc = sc; e.ec = ec; e.mx = mx; e.se = se; e.mk = mk;
    sbq.push_back(e);
  endtask

  // Monitor: one window result per rising done
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done && !done_prev) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        e = sbq.pop_front();
        chk("sb_sample_cnt", sample_cnt, e.sc);
        chk("sb_err_cnt", err_cnt, e.ec);
        chk("sb_max_ed", max_ed, e.mx);
        chk("sb_sum_ed", sum_ed, e.se);
        chk("sb_mask", mask, e.mk);
      end
    end
    done_prev = rst_n & done;
  end

  task automatic do_start(input int sel, input int n);
    @(negedge clk);
    num_samples = n;
    if (sel == 1) start1 = 1'b1;
    else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic send(input int sel,
                      input logic [15:0] a, b,
                      input logic [16:0] s);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_sum = s;
    n = 0;
    while (!(sel == 1 ? in_ready1 : in_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=%0d required<20", n);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int sel, input int exp,
                           input string name);
    int n;
    n = 0;
    while (!(sel == 1 ? done1 : done) && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, n, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_flags", {in_ready, busy, done}, 0);
    rst_n = 1'b1;

    // exact triples, done 3 edges after last accept
    do_start(0, 4);
    push(4, 0, 0, 0, 0);
    repeat (4) send(0, 16'h00FF, 16'h0001, 17'h00100);
    wait_done(0, 3, "lat_exact");

    // num_samples=0 acts as 1; carry-out error;
    // valid held during start is not taken that edge
    @(negedge clk);
    num_samples = 0;
    start0 = 1'b1;
    in_valid = 1'b1;
    in_a = 16'hFFFF;
    in_b = 16'h0001;
    in_sum = 17'h00000;
    push(1, 1, 17'h10000, 48'd65536, 17'h10000);
    @(posedge clk);
    #1 start0 = 1'b0;
    chk("start_no_accept", sample_cnt, 0);
    chk("start_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("first_accept", sample_cnt, 1);
    wait_done(0, 3, "lat_carry");

    // exact 0x1334: -3 then +5
    do_start(0, 2);
    push(2, 2, 5, 8, 17'h0000D);
    send(0, 16'h1234, 16'h0100, 17'h01331);
    send(0, 16'h1234, 16'h0100, 17'h01339);
    wait_done(0, 3, "lat_mixed");

    // gapped valid, extra valid refused in DRAIN
    do_start(0, 3);
    push(3, 1, 1, 1, 1);
    send(0, 16'h0001, 16'h0002, 17'h00003);
    @(negedge clk);
    send(0, 16'h8000, 16'h8000, 17'h10000);
    @(negedge clk);
    send(0, 16'h00AA, 16'h0055, 17'h000FE);
    @(negedge clk);
    in_valid = 1'b1;
    chk("drain_ready", in_ready, 0);
    chk("drain_busy", busy, 1);
    chk("drain_cnt", sample_cnt, 3);
    wait_done(0, 3, "lat_gaps");
    in_valid = 1'b0;

    // restart mid-run discards in-flight errors
    do_start(0, 5);
    send(0, 16'h0000, 16'h0000, 17'h00010);
    send(0, 16'h0000, 16'h0000, 17'h00010);
    do_start(0, 5);
    chk("restart_cnt", sample_cnt, 0);
    push(5, 1, 1, 1, 1);
    repeat (4) send(0, 16'h0010, 16'h0020, 17'h00030);
    send(0, 16'h0010, 16'h0020, 17'h00031);
    wait_done(0, 3, "lat_restart");

    // clear beats start
    @(negedge clk);
    clear = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start0 = 1'b0;
    chk("clr_flags", {in_ready, busy, done}, 0);
    chk("clr_cnt", sample_cnt, 0);
    chk("clr_err", err_cnt, 0);
    chk("clr_max", max_ed, 0);
    chk("clr_sum", sum_ed, 0);
    chk("clr_mask", mask, 0);

    // saturation on the narrow instance
    do_start(1, 3);
    repeat (3) send(1, 16'h0000, 16'h0000, 17'h1FFFF);
    wait_done(1, 3, "lat_sat");
    chk("sat_sum_ed", sum_ed1, 18'h3FFFF);
    chk("sat_err_cnt", err_cnt1, 3);
    chk("sat_max_ed", max_ed1, 17'h1FFFF);
    chk("sat_cnt", sample_cnt1, 3);

    // async reset mid-window
    do_start(0, 5);
    send(0, 16'h0000, 16'h0000, 17'h00010);
    send(0, 16'h0000, 16'h0000, 17'h00010);
    repeat (4) @(posedge clk);
    #1 chk("pre_rst_err", err_cnt, 2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_cnt", sample_cnt, 0);
    chk("arst_err", err_cnt, 0);
    chk("arst_max", max_ed, 0);
    chk("arst_sum", sum_ed, 0);
    chk("arst_mask", mask, 0);
    chk("arst_flags", {in_ready, busy, done}, 0);
    chk("arst_sum1", sum_ed1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    chk("sb_leftover", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
